// File: rtl/n64_cfg_scheduler.sv
// Two-port round-robin command scheduler in front of the MCU executor.
// Optional watchdog abort of stalled commands: define CFG_SCHED_TIMEOUT_EN.
module n64_cfg_scheduler #(
  parameter int TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic [1:0]       req_valid,
  input  logic [1:0][7:0]  req_cmd,
  input  logic [1:0][63:0] req_arg,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic             rsp_error,
  output logic [63:0]      rsp_data,
  output logic             mcu_cmd_valid,
  output logic [7:0]       mcu_cmd,
  output logic [63:0]      mcu_arg,
  output logic             mcu_src,
  input  logic             mcu_cmd_done,
  input  logic             mcu_cmd_error,
  input  logic [63:0]      mcu_rdata,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } state_t;

  state_t state;
  state_t state_nx;

  logic last_grant;
  logic gnt;
  logic hs;
  logic expire;

  // Round-robin pick: on contention the port that did not win last time goes.
  always_comb begin
    gnt = 1'b0;
    if (&req_valid) begin
      gnt = ~last_grant;
    end else if (req_valid[1]) begin
      gnt = 1'b1;
    end
  end

  assign hs = reset && (state == IDLE) && (|req_valid) && !abort;

`ifdef CFG_SCHED_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - 1'b1;

  logic [TIMEOUT_W-1:0] wd_cnt;

  assign expire = (state == ISSUE) && (wd_cnt == WD_LAST)
               && !mcu_cmd_done && !abort;

  // Watchdog: cleared on accept, counts ISSUE cycles, saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (hs) begin
      wd_cnt <= '0;
    end else if ((state == ISSUE) && (wd_cnt != WD_LAST)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_wd;

  assign unused_wd = ^TIMEOUT_CYCLES;
  assign expire    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-state outputs; abort beats completion.
  always_comb begin
    state_nx      = state;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    mcu_cmd_valid = 1'b0;
    busy          = 1'b0;
    timeout       = expire;
    unique case (state)
      IDLE: begin
        if (hs) begin
          req_ready = 2'b01 << gnt;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        mcu_cmd_valid = 1'b1;
        busy          = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (mcu_cmd_done || expire) begin
          state_nx = RESPOND;
        end
      end
      RESPOND: begin
        busy     = 1'b1;
        state_nx = IDLE;
        if (!abort) begin
          rsp_valid = 2'b01 << mcu_src;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Command latch on accept, result latch on completion or watchdog expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      mcu_cmd    <= '0;
      mcu_arg    <= '0;
      mcu_src    <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      if (hs) begin
        mcu_cmd    <= req_cmd[gnt];
        mcu_arg    <= req_arg[gnt];
        mcu_src    <= gnt;
        last_grant <= gnt;
      end
      if ((state == ISSUE) && !abort) begin
        if (mcu_cmd_done) begin
          rsp_data  <= mcu_rdata;
          rsp_error <= mcu_cmd_error;
        end else if (expire) begin
          rsp_data  <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_cfg_scheduler.sv
// Directed bench for n64_cfg_scheduler.
// Watchdog scenarios follow CFG_SCHED_TIMEOUT_EN.
module tb_n64_cfg_scheduler;

  logic             clk;
  logic             reset;
  logic             abort;
  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_cmd;
  logic [1:0][63:0] req_arg;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic             rsp_error;
  logic [63:0]      rsp_data;
  logic             mcu_cmd_valid;
  logic [7:0]       mcu_cmd;
  logic [63:0]      mcu_arg;
  logic             mcu_src;
  logic             mcu_cmd_done;
  logic             mcu_cmd_error;
  logic [63:0]      mcu_rdata;
  logic             busy;
  logic             timeout;

  int n_chk;
  int n_fail;

  n64_cfg_scheduler #(
    .TIMEOUT_W(24),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .abort(abort),
    .req_valid(req_valid),
    .req_cmd(req_cmd),
    .req_arg(req_arg),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_error(rsp_error),
    .rsp_data(rsp_data),
    .mcu_cmd_valid(mcu_cmd_valid),
    .mcu_cmd(mcu_cmd),
    .mcu_arg(mcu_arg),
    .mcu_src(mcu_src),
    .mcu_cmd_done(mcu_cmd_done),
    .mcu_cmd_error(mcu_cmd_error),
    .mcu_rdata(mcu_rdata),
    .busy(busy),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input logic [63:0] d, input logic err);
    mcu_cmd_done  = 1'b1;
    mcu_rdata     = d;
    mcu_cmd_error = err;
    step();
    mcu_cmd_done  = 1'b0;
    mcu_cmd_error = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, mcu_cmd_valid, mcu_cmd, mcu_arg,
         mcu_src, busy, timeout, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero output(s) busy=%b cmd=%h rsp=%h",
               busy, mcu_cmd, rsp_data);
    end
    req_valid = 2'b11;
    #1;
    n_chk++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    req_valid = 2'b00;
    reset = 1'b1;
    step();
  endtask

  task automatic test_contention();
    logic e;
    req_cmd[0] = 8'h20;
    req_cmd[1] = 8'h31;
    req_arg[0] = 64'hA0;
    req_arg[1] = 64'hB1;
    req_valid  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      e = (i == 1);
      #1;
      n_chk++;
      if (req_ready !== (2'b01 << e)) begin
        n_fail++;
        $display("FAIL cont_ready[%0d]: got %b expected %b", i, req_ready, 2'b01 << e);
      end
      step();
      n_chk++;
      if ({req_ready, mcu_src, mcu_cmd} !== {2'b00, e, (e ? 8'h31 : 8'h20)}) begin
        n_fail++;
        $display("FAIL cont_issue[%0d]: got rdy=%b src=%b cmd=%h expected src=%b",
                 i, req_ready, mcu_src, mcu_cmd, e);
      end
      complete(64'h100 + 64'(i), 1'b0);
      n_chk++;
      if ({rsp_valid, rsp_data} !== {(2'b01 << e), 64'h100 + 64'(i)}) begin
        n_fail++;
        $display("FAIL cont_rsp[%0d]: got v=%b d=%h expected v=%b d=%h",
                 i, rsp_valid, rsp_data, 2'b01 << e, 64'h100 + 64'(i));
      end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    req_cmd[0] = 8'h10;
    req_arg[0] = 64'h1234;
    req_valid  = 2'b01;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    n_chk++;
    if ({mcu_cmd_valid, mcu_cmd, mcu_arg, mcu_src, busy} !==
        {1'b1, 8'h10, 64'h1234, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b cmd=%h arg=%h src=%b busy=%b",
               mcu_cmd_valid, mcu_cmd, mcu_arg, mcu_src, busy);
    end
    for (int k = 0; k < 4; k++) step();
    n_chk++;
    if ({mcu_cmd_valid, mcu_cmd, mcu_arg} !== {1'b1, 8'h10, 64'h1234}) begin
      n_fail++;
      $display("FAIL single_stable: got v=%b cmd=%h arg=%h",
               mcu_cmd_valid, mcu_cmd, mcu_arg);
    end
    complete(64'hAB, 1'b0);
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, mcu_cmd_valid} !==
        {2'b01, 1'b0, 64'hAB, 1'b0}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b e=%b d=%h cv=%b expected 01/0/ab/0",
               rsp_valid, rsp_error, rsp_data, mcu_cmd_valid);
    end
    step();
    n_chk++;
    if ({rsp_valid, busy, rsp_data} !== {2'b00, 1'b0, 64'hAB}) begin
      n_fail++;
      $display("FAIL single_after: got v=%b busy=%b d=%h expected 00/0/ab",
               rsp_valid, busy, rsp_data);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    req_cmd[1] = 8'h42;
    req_valid  = 2'b10;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL to_ready: got %b expected 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    bad = 1'b0;
`ifdef CFG_SCHED_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      #1;
      if (timeout !== 1'b0) bad = 1'b1;
      step();
    end
    n_chk++;
    if ({bad, timeout, mcu_cmd_valid} !== 3'b011) begin
      n_fail++;
      $display("FAIL to_pulse: got early=%b to=%b cv=%b expected 0/1/1",
               bad, timeout, mcu_cmd_valid);
    end
    step();
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, mcu_cmd_valid, timeout} !==
        {2'b10, 1'b1, 64'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL to_rsp: got v=%b e=%b d=%h cv=%b to=%b",
               rsp_valid, rsp_error, rsp_data, mcu_cmd_valid, timeout);
    end
    step();
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    bad = 1'b0;
    for (int k = 1; k < 16; k++) step();
    mcu_cmd_done = 1'b1;
    mcu_rdata    = 64'h55;
    #1;
    n_chk++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_race: got timeout=%b expected 0", timeout);
    end
    step();
    mcu_cmd_done = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, timeout} !==
        {2'b10, 1'b0, 64'h55, 1'b0}) begin
      n_fail++;
      $display("FAIL to_done_rsp: got v=%b e=%b d=%h to=%b",
               rsp_valid, rsp_error, rsp_data, timeout);
    end
`else
    for (int k = 0; k < 40; k++) begin
      #1;
      if ((timeout !== 1'b0) || (mcu_cmd_valid !== 1'b1)) bad = 1'b1;
      step();
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL nto_wait: got abnormal timeout/valid=%b expected 0", bad);
    end
    complete(64'h55, 1'b0);
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, timeout} !==
        {2'b10, 1'b0, 64'h55, 1'b0}) begin
      n_fail++;
      $display("FAIL nto_rsp: got v=%b e=%b d=%h to=%b",
               rsp_valid, rsp_error, rsp_data, timeout);
    end
`endif
    step();
  endtask

  task automatic test_abort();
    logic bad;
    req_cmd[0] = 8'h70;
    req_valid  = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    abort        = 1'b1;
    mcu_cmd_done = 1'b1;
    mcu_rdata    = 64'hDEAD;
    step();
    abort        = 1'b0;
    mcu_cmd_done = 1'b0;
    #1;
    n_chk++;
    if ({busy, mcu_cmd_valid, rsp_valid, rsp_data} !== {1'b0, 1'b0, 2'b00, 64'h55}) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b cv=%b v=%b d=%h expected 0/0/00/55",
               busy, mcu_cmd_valid, rsp_valid, rsp_data);
    end
    mcu_cmd_done = 1'b1;
    mcu_rdata    = 64'hBEEF;
    step();
    mcu_cmd_done = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if ((rsp_valid !== 2'b00) || (busy !== 1'b0)) bad = 1'b1;
      step();
    end
    n_chk++;
    if ({bad, rsp_data} !== {1'b0, 64'h55}) begin
      n_fail++;
      $display("FAIL abort_late_done: got bad=%b d=%h expected 0/55", bad, rsp_data);
    end
    req_valid = 2'b11;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_next_ready: got %b expected 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    complete(64'h77, 1'b1);
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 1'b1, 64'h77}) begin
      n_fail++;
      $display("FAIL abort_next_rsp: got v=%b e=%b d=%h expected 10/1/77",
               rsp_valid, rsp_error, rsp_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req_cmd[0] = 8'h66;
    req_arg[0] = 64'hCAFE;
    req_valid  = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_error, rsp_data, mcu_cmd_valid, mcu_cmd, mcu_arg,
         mcu_src, busy, timeout, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b cv=%b cmd=%h arg=%h expected 0",
               busy, mcu_cmd_valid, mcu_cmd, mcu_arg);
    end
    step();
    step();
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    complete(64'h1, 1'b0);
    step();
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    reset         = 1'b0;
    abort         = 1'b0;
    req_valid     = 2'b00;
    req_cmd       = '0;
    req_arg       = '0;
    mcu_cmd_done  = 1'b0;
    mcu_cmd_error = 1'b0;
    mcu_rdata     = '0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_cfg_scheduler.md
# n64_cfg_scheduler

Command scheduler that shares the single MCU command executor between two requesters: port 0 is the N64 configuration mailbox and port 1 is the USB/debug command path. It round-robin arbitrates, latches one command with its 64-bit argument, and presents it to the MCU side. It then returns the result or error to the originating requester. An optional watchdog aborts commands the MCU never completes.

## Interface
- TIMEOUT_W, 24: width of the watchdog counter.
- TIMEOUT_CYCLES, 24'd10_000_000: number of ISSUE cycles before a command is declared timed out.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- abort  in  1  synchronous flush, driven by N64 reset/NMI
- req_valid  in  [1:0]  per-requester command request; held until accepted
- req_cmd  in  [1:0][7:0]  command code per requester
- req_arg  in  [1:0][63:0]  argument per requester ({data0, data1})
- req_ready  out  [1:0]  combinational one-hot accept
- rsp_valid  out  [1:0]  one-cycle completion pulse to the originating requester
- rsp_error  out  1  error flag, qualified by rsp_valid
- rsp_data  out  64  result data, qualified by rsp_valid
- mcu_cmd_valid  out  1  command pending toward the MCU; level signal
- mcu_cmd  out  8  latched command code
- mcu_arg  out  64  latched argument
- mcu_src  out  1  index of the granted requester
- mcu_cmd_done  in  1  MCU completion strobe
- mcu_cmd_error  in  1  MCU error, qualified by mcu_cmd_done
- mcu_rdata  in  64  MCU result, qualified by mcu_cmd_done
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- The FSM has three states: IDLE, ISSUE and RESPOND.
- IDLE
  - Grant is round-robin over req_valid, using pointer last_grant.
  - When both requests are valid, the port != last_grant wins. A single valid request wins outright.
  - req_ready[g] = 1 in IDLE for the granted port only.
  - On handshake: latch cmd/arg/src, set last_grant <= g, clear the watchdog, go to ISSUE.
- ISSUE
  - mcu_cmd_valid = 1. mcu_cmd, mcu_arg and mcu_src stay stable.
  - On mcu_cmd_done: latch rsp_data <= mcu_rdata and rsp_error <= mcu_cmd_error, go to RESPOND.
- RESPOND
  - rsp_valid[src] = 1 for exactly one cycle, then go to IDLE.
- abort, in any state, forces IDLE on the next edge.
  - No rsp_valid is produced. mcu_cmd_valid drops. last_grant is kept.
  - A late mcu_cmd_done arriving in IDLE is ignored.
- mcu_cmd_done in IDLE or RESPOND is ignored.
- abort has priority over mcu_cmd_done in the same cycle.
- Reset values: state = IDLE; last_grant = 1, so port 0 wins first; all outputs 0; rsp_data = 0; mcu_cmd and mcu_arg = 0.

## Timing
- Handshake in cycle N: mcu_cmd_valid = 1 from cycle N+1.
- mcu_cmd_done sampled at edge M: rsp_valid is high during cycle M+1, and state is IDLE in cycle M+2.
- The earliest next grant is in cycle M+2, so minimum command turnaround is 3 cycles.
- rsp_data and rsp_error hold their value until the next response.
- Reset is asynchronous on assertion. Deassertion is synchronized upstream.

## Configuration
- CFG_SCHED_TIMEOUT_EN defined:
  - The watchdog counts ISSUE cycles.
  - When the count reaches TIMEOUT_CYCLES-1 without mcu_cmd_done:
    - go to RESPOND with rsp_error = 1 and rsp_data = 0;
    - pulse timeout for one cycle;
    - drop mcu_cmd_valid.
  - mcu_cmd_done in the same cycle as expiry wins: normal response, no timeout pulse.
  - The counter saturates, so it never wraps.
- CFG_SCHED_TIMEOUT_EN undefined:
  - No counter is present.
  - timeout is tied to 0.
  - ISSUE waits indefinitely for mcu_cmd_done or abort.

## Test plan
- Single request: req_valid = 01, cmd 8'h10, arg 64'h1234; done after 5 cycles with rdata 64'hAB.
  - Required: mcu_cmd = 8'h10, mcu_src = 0; rsp_valid = 01 for one cycle with rsp_data = 64'hAB and rsp_error = 0.
- Contention: both ports held valid for three commands.
  - Required: grant order 0, 1, 0; each port's req_ready is a single-cycle pulse.
- Timeout (macro on, TIMEOUT_CYCLES = 16, no done):
  - Required: timeout pulse at the 16th ISSUE cycle; rsp_valid to src with rsp_error = 1 and rsp_data = 0.
  - Then assert done in the same cycle as expiry. Required: normal response, timeout stays 0.
- Abort mid-ISSUE, then a late mcu_cmd_done.
  - Required: no rsp_valid, busy = 0 on the next cycle; the next request is accepted normally.
- Reset asserted mid-ISSUE.
  - Required: all outputs 0 immediately, asynchronously; after release, port 0 is granted first when both ports request.
